// File: rtl/lsu_subword.sv
// Sub-word load/store adapter in front of a word-only data memory.
// SB/SH are done as a read-modify-write over two cycles.
module lsu_subword (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] waddr_q, waddr_d;

    logic [31:0] aligned;
    logic [1:0]  lane;
    logic        is_b, is_h, is_w, bad;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;
    logic [31:0] st_merge;

    assign lane    = addr[1:0];
    assign aligned = {addr[31:2], 2'b00};
    assign is_b    = (funct3 == 3'b000) || (funct3 == 3'b100);
    assign is_h    = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign is_w    = (funct3 == 3'b010);
    assign ld_b    = mem_rdata[{lane, 3'b000} +: 8];
    assign ld_h    = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // Unsigned variants only exist for loads.
    assign bad = !(is_b || is_h || is_w)
               || (is_h && addr[0])
               || (is_w && (lane != 2'b00))
               || (req_we && funct3[2]);

    always_comb begin
        unique case (funct3)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_ext = {24'b0, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_ext = {16'b0, ld_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        st_merge = mem_rdata;
        if (is_b) begin
            st_merge[{lane, 3'b000} +: 8] = wdata[7:0];
        end else begin
            st_merge[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        merge_d   = merge_q;
        waddr_d   = waddr_q;
        rdata     = '0;
        stall     = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        mem_addr  = aligned;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        // Holding reset must silence the memory port even with a live request.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (bad) begin
                            fault = 1'b1;
                            done  = 1'b1;
                        end else if (!req_we) begin
                            mem_re = 1'b1;
                            done   = 1'b1;
                            rdata  = ld_ext;
                        end else if (is_w) begin
                            mem_we    = 1'b1;
                            mem_wdata = wdata;
                            done      = 1'b1;
                        end else begin
                            mem_re  = 1'b1;
                            stall   = 1'b1;
                            merge_d = st_merge;
                            waddr_d = aligned;
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    mem_we    = 1'b1;
                    mem_addr  = waddr_q;
                    mem_wdata = merge_q;
                    done      = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            merge_q <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            waddr_q <= waddr_d;
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: table-driven loads/faults with a scoreboard,
// plus hand-written RMW, back-to-back and reset-abort sequences.
module tb_lsu_subword;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    lsu_subword dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .done      (done),
        .fault     (fault),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory, with a preload port so only one process writes it.
    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ef;
        logic        ere;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req_valid = 1'b0;
        pl_en = 1'b1; pl_idx = a[7:2]; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; funct3 = f3;
        addr = a; wdata = wd;
    endtask

    task automatic idle_req();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Issue a request, push its expectation, pop and compare on done.
    task automatic run_req(input string name, input logic we,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] er,
                           input logic ef, input int ecyc);
        exp_t e;
        int   n;
        bit   got;
        e.rdata = er;
        e.fault = ef;
        sb_q.push_back(e);
        drive(we, f3, a, wd);
        n = 0;
        got = 1'b0;
        while (!got && n < 4) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1'b1;
                e = sb_q.pop_front();
                chk({name, ".rdata"}, rdata, e.rdata);
                chk({name, ".fault"}, {31'b0, fault}, {31'b0, e.fault});
                chk({name, ".stall_with_done"}, {31'b0, stall}, 32'd0);
                chk({name, ".cycles"}, n, ecyc);
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: got no done expected done in %0d",
                     name, ecyc);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        funct3 = 3'b000; addr = 32'h123; wdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;

        vt[0]  = '{"LB40",  1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFF4, 1'b0, 1'b1};
        vt[1]  = '{"LBU40", 1'b0, 3'b100, 32'h40, 32'h0, 32'h000000F4, 1'b0, 1'b1};
        vt[2]  = '{"LB43",  1'b0, 3'b000, 32'h43, 32'h0, 32'h00000011, 1'b0, 1'b1};
        vt[3]  = '{"LH42",  1'b0, 3'b001, 32'h42, 32'h0, 32'h00001122, 1'b0, 1'b1};
        vt[4]  = '{"LB41",  1'b0, 3'b000, 32'h41, 32'h0, 32'h00000033, 1'b0, 1'b1};
        vt[5]  = '{"LHU40", 1'b0, 3'b101, 32'h40, 32'h0, 32'h000033F4, 1'b0, 1'b1};
        vt[6]  = '{"LW40",  1'b0, 3'b010, 32'h40, 32'h0, 32'h112233F4, 1'b0, 1'b1};
        vt[7]  = '{"LW42",  1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[8]  = '{"SH41",  1'b1, 3'b001, 32'h41, 32'hFFFF, 32'h0, 1'b1, 1'b0};
        vt[9]  = '{"F011",  1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[10] = '{"SBU40", 1'b1, 3'b100, 32'h40, 32'h77, 32'h0, 1'b1, 1'b0};

        // Reset values while held in reset and with no request.
        #1;
        chk("rst.mem_addr", mem_addr, 32'h120);
        chk("rst.done", {31'b0, done}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle.mem_we", {31'b0, mem_we}, 32'd0);
        chk("idle.mem_re", {31'b0, mem_re}, 32'd0);
        chk("idle.stall", {31'b0, stall}, 32'd0);
        chk("idle.rdata", rdata, 32'd0);

        preload(32'h40, 32'h112233F4);
        for (int i = 0; i < 11; i++) begin
            run_req(vt[i].name, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd,
                    vt[i].er, vt[i].ef, 1);
            chk({vt[i].name, ".mem_re"}, {31'b0, mem_re}, {31'b0, vt[i].ere});
            chk({vt[i].name, ".mem_we"}, {31'b0, mem_we}, 32'd0);
        end
        idle_req();
        @(negedge clk);
        chk("fault.mem_unchanged", mem[16], 32'h112233F4);

        // SB read-modify-write, cycle by cycle.
        preload(32'h40, 32'h11223344);
        drive(1'b1, 3'b000, 32'h41, 32'h000000AB);
        @(negedge clk);
        chk("sb.c0.stall", {31'b0, stall}, 32'd1);
        chk("sb.c0.mem_re", {31'b0, mem_re}, 32'd1);
        chk("sb.c0.done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("sb.c1.mem_we", {31'b0, mem_we}, 32'd1);
        chk("sb.c1.mem_addr", mem_addr, 32'h40);
        chk("sb.c1.mem_wdata", mem_wdata, 32'h1122AB44);
        chk("sb.c1.done", {31'b0, done}, 32'd1);
        chk("sb.c1.stall", {31'b0, stall}, 32'd0);
        run_req("LW.after_sb", 1'b0, 3'b010, 32'h40, 32'h0,
                32'h1122AB44, 1'b0, 1);
        idle_req();

        // Back-to-back SH then SB on the same word.
        preload(32'h40, 32'h11223344);
        run_req("SH42", 1'b1, 3'b001, 32'h42, 32'h0000BEEF, 32'h0, 1'b0, 2);
        run_req("SB40", 1'b1, 3'b000, 32'h40, 32'h00000099, 32'h0, 1'b0, 2);
        chk("b2b.after_sh", mem[16], 32'hBEEF3344);
        run_req("LW.b2b", 1'b0, 3'b010, 32'h40, 32'h0, 32'hBEEF3399, 1'b0, 1);
        idle_req();

        // Reset asserted during the WRITE cycle aborts the store.
        preload(32'h44, 32'h01020304);
        drive(1'b1, 3'b000, 32'h44, 32'h00000055);
        @(negedge clk);
        chk("rstw.c0.stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("rstw.c1.mem_we", {31'b0, mem_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rstw.mem_we_drop", {31'b0, mem_we}, 32'd0);
        chk("rstw.done_drop", {31'b0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw.mem_kept", mem[17], 32'h01020304);
        run_req("LW.after_rst", 1'b0, 3'b010, 32'h44, 32'h0,
                32'h01020304, 1'b0, 1);
        idle_req();

        // SW single cycle, then unsigned half load.
        drive(1'b1, 3'b010, 32'h80, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw.mem_we", {31'b0, mem_we}, 32'd1);
        chk("sw.stall", {31'b0, stall}, 32'd0);
        chk("sw.done", {31'b0, done}, 32'd1);
        chk("sw.mem_wdata", mem_wdata, 32'hDEADBEEF);
        run_req("LHU82", 1'b0, 3'b101, 32'h82, 32'h0, 32'h0000DEAD, 1'b0, 1);
        run_req("LH82", 1'b0, 3'b001, 32'h82, 32'h0, 32'hFFFFDEAD, 1'b0, 1);
        idle_req();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit sitting directly upstream of the word-only data memory in the single-cycle core. Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses, extracting and extending load data. SB/SH become a two-cycle read-modify-write with a stall to the core, because the memory has no byte enables. Misaligned and illegal accesses are flagged and never reach memory.

## Interface
Parameters: none; data and address paths are fixed at 32 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core issues a load/store this cycle
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result
- stall  out  1  core must hold PC and request stable
- done  out  1  access completes this cycle
- fault  out  1  misaligned or illegal access this cycle
- mem_addr  out  32  to memory: word-aligned address
- mem_wdata  out  32  to memory: full write word
- mem_we  out  1  to memory: write enable, committed on clk rising edge
- mem_re  out  1  to memory: read enable
- mem_rdata  in  32  from memory: combinational read data

## Operation
- States: IDLE, WRITE. Reset state is IDLE. Reset also clears the merge and address registers to 0.
- Lane: lane = addr[1:0].
- Fault, evaluated in IDLE with req_valid=1. Fault is raised for any of:
  - H/HU/SH with addr[0]=1
  - W with addr[1:0]≠0
  - funct3 ∈ {011,110,111}
  - load with funct3 ∈ {100,101} and req_we=1 (BU/HU stores)
- Fault response: fault=1, done=1, mem_re=0, mem_we=0, stall=0, rdata=0, state unchanged.
- Load (IDLE, no fault):
  - mem_addr={addr[31:2],2'b00}, mem_re=1, done=1, stall=0.
  - rdata is combinational from mem_rdata: B/BU take byte [8·lane+7:8·lane], H/HU take half [16·addr[1]+15:16·addr[1]]. B/H sign-extend; BU/HU zero-extend; W passes through.
- SW (IDLE, no fault): mem_we=1, mem_wdata=wdata, done=1, stall=0.
- SB/SH (IDLE, no fault):
  - mem_re=1 and stall=1.
  - Register merge = mem_rdata with the selected byte/half replaced by wdata[7:0] / wdata[15:0]; register the word address.
  - Go to WRITE.
- WRITE:
  - mem_we=1, mem_addr=registered address, mem_wdata=merge, done=1, stall=0.
  - Go to IDLE. Request inputs are ignored in this state.
- IDLE with req_valid=0: all outputs 0 except mem_addr, which follows {addr[31:2],2'b00}.

## Timing
- Load, SW, fault: 0 extra cycles; done is asserted in the request cycle.
- SB/SH: 2 cycles. Cycle 0 has stall=1, done=0; cycle 1 has done=1. The memory word is updated at the rising edge ending cycle 1.
- Core must hold req_* stable while stall=1. The block does not check this. WRITE always uses the data registered at the end of cycle 0.
- Back-to-back SB/SH to the same word: the second read occurs after the first write edge, so both updates survive.
- rst_n low at any time: state goes to IDLE immediately (async). mem_we, stall and done drop combinationally, and an in-flight RMW is discarded without a write.
- rst_n deassertion is synchronised externally. The first request is accepted on the first edge after release.
- done is never asserted together with stall.

## Test plan
- Memory[0x40]=0x112233F4. LB 0x40 -> rdata 0xFFFFFFF4. LBU 0x40 -> 0x000000F4. LB 0x43 -> 0x00000011. LH 0x42 -> 0x00001122. All single cycle with done=1.
- Memory[0x40]=0x11223344, SB 0x41 wdata 0xAB:
  - cycle 0: stall=1, mem_re=1.
  - cycle 1: mem_we=1, mem_addr=0x40, mem_wdata=0x1122AB44, done=1.
  - then LW 0x40 -> 0x1122AB44.
- SH 0x42 wdata 0x0000BEEF on 0x11223344 -> memory 0xBEEF3344. Then SB 0x40 wdata 0x99 back-to-back -> 0xBEEF3399.
- LW 0x42, SH 0x41, funct3=011 -> each gives fault=1, done=1, mem_we=0, mem_re=0, stall=0, with memory unchanged.
- SB 0x44 wdata 0x55 with rst_n pulsed low during the WRITE cycle -> mem_we falls immediately, Memory[0x44] keeps its old value, block is in IDLE after release.
- SW 0x80 wdata 0xDEADBEEF -> mem_we=1 in the same cycle, stall=0. Then LHU 0x82 -> 0x0000DEAD.
